// File: rtl/serial_arith_pkg.sv
// Shared definitions for the digit-serial arithmetic blocks: FSM state
// encoding, digit width and a counter-width helper.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DIGIT_W = 2;

  // Bits needed to count n digits; never less than one so a single-digit
  // build still has a legal counter vector.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/digit_sub2.sv
// One 2-bit digit of subtraction: {bo, d} = a - b - bi, evaluated 3 bits
// wide so the borrow falls out as the top bit.
module digit_sub2
  import serial_arith_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               bi,
  output logic [DIGIT_W-1:0] d,
  output logic               bo
);

  logic [DIGIT_W:0] full;

  // Zero-extended subtraction; a negative result wraps and sets the top bit.
  always_comb begin
    full = {1'b0, a} - {1'b0, b} - {{DIGIT_W{1'b0}}, bi};
    d    = full[DIGIT_W-1:0];
    bo   = full[DIGIT_W];
  end

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin, one 2-bit digit per clock,
// least-significant digit first, valid/ready handshakes on both sides.
// Optional macro SERIAL_SUBTRACTOR_OVF_EN adds a signed-overflow output ovf.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NDIG  = WIDTH / DIGIT_W;
  localparam int CNT_W = clog2(NDIG);
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("serial_subtractor: WIDTH must be even and >= 2");
  end

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               borrow;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [CNT_W:0]     idx;
  logic [DIGIT_W-1:0] a_dig, b_dig, d_dig;
  logic               bo_dig;
  logic               accept;

  assign accept = (state == S_IDLE) && in_valid;
  assign idx    = {cnt, 1'b0};
  assign a_dig  = a_q[idx +: DIGIT_W];
  assign b_dig  = b_q[idx +: DIGIT_W];

  // The single digit slice, time-multiplexed over all digits by cnt.
  digit_sub2 u_digit (
    .a  (a_dig),
    .b  (b_dig),
    .bi (borrow),
    .d  (d_dig),
    .bo (bo_dig)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake decode; in_ready/out_valid come straight from state.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_BUSY;
      end
      S_BUSY: begin
        if (cnt == LAST_DIG) state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operands are captured only on accept, so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b;
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  // Borrow from the digit's low bit into its high bit; on the top digit this
  // is the borrow into the sign bit.
  logic msb_bi;
  assign msb_bi = (~a_dig[0] & b_dig[0]) | (~(a_dig[0] ^ b_dig[0]) & borrow);
`endif

  // Digit counter, running borrow and the result written one digit per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      borrow <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            cnt    <= '0;
            borrow <= bin;
            diff   <= '0;
          end
        end
        S_BUSY: begin
          diff[idx +: DIGIT_W] <= d_dig;
          borrow               <= bo_dig;
          cnt                  <= cnt + 1'b1;
          if (cnt == LAST_DIG) begin
            bout <= bo_dig;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf  <= msb_bi ^ bo_dig;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH = 8): vector table driven
// through a scoreboard, plus back-pressure, async reset abort and
// back-to-back sequences. Checks ovf when SERIAL_SUBTRACTOR_OVF_EN is defined.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       bin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] diff;
  logic       bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic       ovf;
`endif

  serial_subtractor #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } vec_t;

  typedef struct {
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } exp_t;

  vec_t vecs[11];
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic check_result(input string nm, input exp_t e);
    check({nm, "_diff"}, 32'(diff), 32'(e.diff));
    check({nm, "_bout"}, 32'(bout), 32'(e.bout));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    check({nm, "_ovf"}, 32'(ovf), 32'(e.ovf));
`endif
  endtask

  // Wait (bounded) for in_ready, then present operands for one accept edge.
  task automatic send(input string nm, input logic [7:0] ta, input logic [7:0] tb,
                      input logic tbin, input exp_t e);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check({nm, "_in_ready"}, 32'(seen), 32'd1);
    a = ta; b = tb; bin = tbin; in_valid = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble inputs while busy; the latched operands must be used.
    a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
  endtask

  // Count edges from the accept edge until out_valid, bounded.
  task automatic wait_result(input string nm, output bit seen);
    int lat;
    lat = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) check({nm, "_latency"}, 32'(lat), 32'd4);
  endtask

  task automatic consume(input string nm);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({nm, "_out_valid_drop"}, 32'(out_valid), 32'd0);
    check({nm, "_in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic do_op(input string nm, input logic [7:0] ta, input logic [7:0] tb,
                       input logic tbin, input exp_t e);
    bit   seen;
    exp_t got;
    send(nm, ta, tb, tbin, e);
    wait_result(nm, seen);
    if (seen && sb.size() > 0) begin
      got = sb.pop_front();
      check_result(nm, got);
    end
    consume(nm);
  endtask

  initial begin
    exp_t e;
    bit   seen;
    int   sent, got_n, last_t;
    bit   acc;
    logic [7:0] bb_a[3];
    logic [7:0] bb_b[3];

    //            a      b      bin   diff   bout  ovf
    vecs[0]  = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0};
    vecs[1]  = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3]  = '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[4]  = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[5]  = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[6]  = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[7]  = '{8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1};
    vecs[8]  = '{8'h5A, 8'hA5, 1'b1, 8'hB4, 1'b1, 1'b1};
    vecs[9]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[10] = '{8'hC3, 8'h3C, 1'b1, 8'h86, 1'b0, 1'b0};

    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Table-driven vectors
    for (int i = 0; i < 11; i++) begin
      e = '{vecs[i].diff, vecs[i].bout, vecs[i].ovf};
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin, e);
    end

    // Back-pressure: result held and new operands ignored while out_ready=0
    e = '{8'h23, 1'b0, 1'b0};
    send("bp", 8'h35, 8'h12, 1'b0, e);
    wait_result("bp", seen);
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      for (int i = 0; i < 10; i++) begin
        in_valid = ~in_valid;
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        @(posedge clk); #1;
        check_result($sformatf("bp_hold%0d", i), e);
        check($sformatf("bp_in_ready%0d", i), 32'(in_ready), 32'd0);
        check($sformatf("bp_out_valid%0d", i), 32'(out_valid), 32'd1);
      end
    end
    in_valid = 1'b0;
    consume("bp");

    // Asynchronous reset two cycles into BUSY aborts the operation
    a = 8'h35; b = 8'h12; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_partial_diff", 32'(diff), 32'h03);
    #1 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_bout", 32'(bout), 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_still_idle", 32'(out_valid), 32'd0);
    do_op("after_abort", 8'h35, 8'h12, 1'b0, '{8'h23, 1'b0, 1'b0});

    // Back-to-back: in_valid and out_ready held high, one result per 6 cycles
    bb_a[0] = 8'h10; bb_b[0] = 8'h01;
    bb_a[1] = 8'h80; bb_b[1] = 8'h80;
    bb_a[2] = 8'h7F; bb_b[2] = 8'h80;
    sent = 0; got_n = 0; last_t = 0;
    out_ready = 1'b1;
    a = bb_a[0]; b = bb_b[0]; bin = 1'b0; in_valid = 1'b1;
    for (int t = 0; t < 40 && got_n < 3; t++) begin
      @(negedge clk);
      acc = in_ready && in_valid;
      if (acc) begin
        case (sent)
          0: sb.push_back('{8'h0F, 1'b0, 1'b0});
          1: sb.push_back('{8'h00, 1'b0, 1'b0});
          default: sb.push_back('{8'hFF, 1'b1, 1'b1});
        endcase
      end
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        if (sent < 3) begin
          a = bb_a[sent]; b = bb_b[sent];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check_result($sformatf("b2b%0d", got_n), e);
        end
        if (got_n > 0) check($sformatf("b2b_spacing%0d", got_n), 32'(t - last_t), 32'd6);
        last_t = t;
        got_n++;
      end
    end
    check("b2b_count", 32'(got_n), 32'd3);
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
